// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame transmitter.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

  localparam int unsigned DEF_DATA_W       = 10;
  localparam int unsigned DEF_CLKS_PER_BIT = 1;

  // Counter width for a range of v values, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module bit_tick_gen
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o,
  output logic tick_next_c
);

  localparam int unsigned DIV_W = clog2_min1(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] TERM = DIV_W'(CLKS_PER_BIT - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // Lookahead lets the parent register flags that line up with the terminal count.
  assign tick_next_c = (cnt_d == TERM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_o <= (TERM == '0);
    end else begin
      cnt_q  <= cnt_d;
      tick_o <= tick_next_c;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter, LSB first, with a one-word holding buffer.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              serial_o,
  output logic              frame_o,
  output logic              done_o,
  output logic              busy_o
);

  localparam int unsigned CNT_W = clog2_min1(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              ready_q, frame_q, done_q, busy_q;
  logic              bit_tick, tick_next_c;
  logic              div_en_c, div_clr_c, xfer_c, last_c;

  assign xfer_c    = valid_i & ready_q;
  assign div_en_c  = (state_q == SHIFT);
  assign div_clr_c = (state_d != SHIFT);

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (div_en_c),
    .clr_i       (div_clr_c),
    .tick_o      (bit_tick),
    .tick_next_c (tick_next_c)
  );

  // Next-state, shift register, bit counter and holding buffer.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    last_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer_c) begin
          state_d   = SHIFT;
          shift_d   = data_i;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        last_c = bit_tick && (bit_cnt_q == LAST_BIT);
        if (last_c) begin
          // Chain the next word with no idle bit time when one is available.
          bit_cnt_d = '0;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (xfer_c) begin
            shift_d = data_i;
          end else begin
            state_d = IDLE;
            shift_d = '0;
          end
        end else begin
          if (bit_tick) begin
            shift_d   = {1'b0, shift_q[DATA_W-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          if (xfer_c) begin
            hold_d      = data_i;
            hold_full_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        shift_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      ready_q     <= 1'b1;
      frame_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      ready_q     <= !hold_full_d;
      frame_q     <= (state_d == SHIFT);
      busy_q      <= (state_d == SHIFT) || hold_full_d;
      // Registered ahead so the pulse sits on the final clock of the last bit.
      done_q      <= (state_d == SHIFT) && (bit_cnt_d == LAST_BIT) && tick_next_c;
    end
  end

  assign ready_o  = ready_q;
  assign serial_o = shift_q[0];
  assign frame_o  = frame_q;
  assign done_o   = done_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx with one-clock and four-clock bit periods.
module tb_serial_frame_tx;

  localparam int unsigned DW   = 10;
  localparam int unsigned CPB1 = 1;
  localparam int unsigned CPB4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [DW-1:0] data1, data4;
  logic          valid1, valid4;
  logic          ready1, serial1, frame1, done1, busy1;
  logic          ready4, serial4, frame4, done4, busy4;

  serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data1), .valid_i(valid1), .ready_o(ready1),
    .serial_o(serial1), .frame_o(frame1), .done_o(done1), .busy_o(busy1)
  );

  serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data4), .valid_i(valid4), .ready_o(ready4),
    .serial_o(serial4), .frame_o(frame4), .done_o(done4), .busy_o(busy4)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q1[$], q4[$];
  logic [DW-1:0] cur1, cur4;
  int pos1 = 0, run1 = 0, last_run1 = 0, frames1 = 0;
  int pos4 = 0, run4 = 0, last_run4 = 0, frames4 = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame monitor, one-clock bit period.
  always @(negedge clk) begin
    if (!rst_n) begin
      q1.delete(); pos1 = 0; run1 = 0;
    end else if (frame1) begin
      run1++;
      if (pos1 == 0) begin
        if (q1.size() == 0) begin
          check("frame1_unexpected", 1, 0); cur1 = '0;
        end else cur1 = q1.pop_front();
      end
      check("serial1", serial1, cur1[pos1 / CPB1]);
      if (pos1 == DW * CPB1 - 1) begin
        check("done1_last", done1, 1); pos1 = 0; frames1++;
      end else begin
        if (done1) check("done1_early", done1, 0);
        pos1++;
      end
    end else begin
      if (run1 != 0) last_run1 = run1;
      run1 = 0;
      if (pos1 != 0) begin check("gap1", pos1, 0); pos1 = 0; end
      if (done1) check("done1_idle", done1, 0);
    end
  end

  // Frame monitor, four-clock bit period.
  always @(negedge clk) begin
    if (!rst_n) begin
      q4.delete(); pos4 = 0; run4 = 0;
    end else if (frame4) begin
      run4++;
      if (pos4 == 0) begin
        if (q4.size() == 0) begin
          check("frame4_unexpected", 1, 0); cur4 = '0;
        end else cur4 = q4.pop_front();
      end
      check("serial4", serial4, cur4[pos4 / CPB4]);
      if (pos4 == DW * CPB4 - 1) begin
        check("done4_last", done4, 1); pos4 = 0; frames4++;
      end else begin
        if (done4) check("done4_early", done4, 0);
        pos4++;
      end
    end else begin
      if (run4 != 0) last_run4 = run4;
      run4 = 0;
      if (pos4 != 0) begin check("gap4", pos4, 0); pos4 = 0; end
      if (done4) check("done4_idle", done4, 0);
    end
  end

  task automatic send1(input logic [DW-1:0] d, output int waited);
    waited = 0; data1 = d; valid1 = 1'b1;
    while (!ready1 && waited < 200) begin @(negedge clk); waited++; end
    if (!ready1) begin check("send1_timeout", 0, 1); valid1 = 1'b0; return; end
    @(posedge clk);
    q1.push_back(d);
    #1 valid1 = 1'b0;
  endtask

  task automatic send4(input logic [DW-1:0] d, output int waited);
    waited = 0; data4 = d; valid4 = 1'b1;
    while (!ready4 && waited < 400) begin @(negedge clk); waited++; end
    if (!ready4) begin check("send4_timeout", 0, 1); valid4 = 1'b0; return; end
    @(posedge clk);
    q4.push_back(d);
    #1 valid4 = 1'b0;
  endtask

  task automatic wait_idle1();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy1 || frame1) && n < 1000);
    check("idle1", busy1 | frame1, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle4();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy4 || frame4) && n < 1000);
    check("idle4", busy4 | frame4, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    rst_n = 1'b0; valid1 = 1'b0; valid4 = 1'b0; data1 = '0; data4 = '0;

    // Reset values, during and after reset.
    @(negedge clk);
    check("rst_ready", ready1, 1); check("rst_serial", serial1, 0);
    check("rst_frame", frame1, 0); check("rst_done", done1, 0);
    check("rst_busy", busy1, 0);   check("rst_ready4", ready4, 1);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_ready", ready1, 1); check("post_serial", serial1, 0);
    check("post_frame", frame1, 0); check("post_done", done1, 0);
    check("post_busy", busy1, 0);
    @(posedge clk); #1;

    // Single frame, one-clock latency.
    send1(10'b1001110100, w);
    @(negedge clk);
    check("lat_frame", frame1, 1);
    check("lat_bit0", serial1, 0);
    wait_idle1();
    check("single_len", last_run1, 10);

    // Back-to-back with valid held: second word lands in the buffer.
    send1(10'h3FF, w);
    send1(10'h000, w);
    check("b2b_ready_low", ready1, 0);
    check("b2b_busy", busy1, 1);
    wait_idle1();
    check("b2b_len", last_run1, 20);

    // Four-clock bit period, then a word taken directly on the last clock.
    send4(10'h155, w);
    wait_idle4();
    check("div_len", last_run4, 40);
    send4(10'h155, w);
    n = 0;
    do begin @(negedge clk); n++; end while (!done4 && n < 100);
    check("div_done_seen", done4, 1);
    send4(10'h0F0, w);
    wait_idle4();
    check("direct_len", last_run4, 80);

    // Back-pressure: third word must wait for the buffer to drain.
    send1(10'h11A, w);
    send1(10'h0C3, w);
    send1(10'h2AA, w);
    check("bp_waited", (w > 0) ? 1 : 0, 1);
    wait_idle1();
    check("bp_len", last_run1, 30);
    check("bp_q_empty", q1.size(), 0);

    // Reset during bit 4 with the buffer full.
    send1(10'h3FF, w);
    send1(10'h155, w);
    repeat (3) @(posedge clk);
    #2 check("pre_rst_serial", serial1, 1);
    check("pre_rst_ready", ready1, 0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_serial", serial1, 0); check("arst_frame", frame1, 0);
    check("arst_busy", busy1, 0);     check("arst_done", done1, 0);
    check("arst_ready", ready1, 1);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send1(10'h001, w);
    wait_idle1();
    check("after_rst_len", last_run1, 10);

    check("frames1", frames1, 7);
    check("frames4", frames4, 3);
    check("q1_empty", q1.size(), 0);
    check("q4_empty", q4.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
